if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register consumed by the decode stage. Applies PC redirects from ID-resolved branches and jumps, honours load-use stalls and IF_Flush from the hazard logic, and parks the pipeline front end when a halt word is fetched.

---
 rtl/if_stage.sv | 172 +++++++++++++++++
 tb/tb_if_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, drives the instruction-memory address and loads IF/ID.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   imem_addr         instruction-memory address (= PC), combinational
//   imem_data         instruction word at imem_addr, same cycle
//   stall             load-use stall: hold PC and IF/ID
//   branch_taken/     ID-resolved branch redirect and its target
//   branch_target
//   jump/jump_target  ID-resolved jump redirect and its target
//   IF_Flush          squash the instruction being fetched
//   instruction_IF    imem_data passthrough
//   PC_sumado_IF      PC+4, combinational
//   instruction_ID    IF/ID instruction
//   PC_sumado_ID      IF/ID PC+4
//   valid_ID          IF/ID holds a real instruction
//   halted            front end parked after fetching HALT_WORD
//   fetch_count       real instructions loaded into IF/ID
//                     (present only with IF_PERF_COUNTER_EN)
//
// Build option: define IF_PERF_COUNTER_EN to add the fetch_count port.

module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        IF_Flush,
    output logic [31:0] instruction_IF,
    output logic [31:0] PC_sumado_IF,
    output logic [31:0] instruction_ID,
    output logic [31:0] PC_sumado_ID,
    output logic        valid_ID,
    output logic        halted
`ifdef IF_PERF_COUNTER_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALTED
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] iid_q;
    logic [31:0] iid_d;
    logic [31:0] pid_q;
    logic [31:0] pid_d;
    logic        vid_q;
    logic        vid_d;

    logic [31:0] pc_plus4;
    logic        squash;
    logic        halt_hit;

    // Targets are word-aligned; the low two bits are dropped.
    logic [3:0]  unused_tgt_lsb;
    assign unused_tgt_lsb = {jump_target[1:0], branch_target[1:0]};

    assign pc_plus4       = pc_q + 32'd4;
    assign squash         = IF_Flush | jump | branch_taken;
    assign halt_hit       = (imem_data == HALT_WORD);

    assign imem_addr      = pc_q;
    assign instruction_IF = imem_data;
    assign PC_sumado_IF   = pc_plus4;
    assign instruction_ID = iid_q;
    assign PC_sumado_ID   = pid_q;
    assign valid_ID       = vid_q;
    assign halted         = (state_q == S_HALTED);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        iid_d   = iid_q;
        pid_d   = pid_q;
        vid_d   = vid_q;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                pc_d    = RESET_PC;
                iid_d   = 32'h0;
                pid_d   = 32'h0;
                vid_d   = 1'b0;
            end
            S_RUN: begin
                if (jump) begin
                    pc_d = {jump_target[31:2], 2'b00};
                end else if (branch_taken) begin
                    pc_d = {branch_target[31:2], 2'b00};
                end else if (!stall) begin
                    pc_d = pc_plus4;
                end
                // A squash wins over a stall: the slot is
                // discarded even while decode is held.
                if (squash) begin
                    iid_d = 32'h0;
                    vid_d = 1'b0;
                    pid_d = pc_plus4;
                end else if (!stall) begin
                    if (halt_hit) begin
                        state_d = S_HALTED;
                        pc_d    = pc_q;
                        iid_d   = 32'h0;
                        vid_d   = 1'b0;
                        pid_d   = pc_plus4;
                    end else begin
                        iid_d = imem_data;
                        vid_d = 1'b1;
                        pid_d = pc_plus4;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            iid_q   <= 32'h0;
            pid_q   <= 32'h0;
            vid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            iid_q   <= iid_d;
            pid_q   <= pid_d;
            vid_q   <= vid_d;
        end
    end

`ifdef IF_PERF_COUNTER_EN
    logic [31:0] fcnt_q;
    logic        fetch_load;

    // Counts exactly the edges that write valid_ID=1.
    assign fetch_load = (state_q == S_RUN) && !squash
                        && !stall && !halt_hit;
    assign fetch_count = fcnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt_q <= 32'h0;
        end else if (fetch_load) begin
            fcnt_q <= fcnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage.
// Reference model predicts IF/ID and PC per cycle; a monitor compares.

module tb_if_stage;

    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        IF_Flush = 1'b0;
    logic [31:0] instruction_IF;
    logic [31:0] PC_sumado_IF;
    logic [31:0] instruction_ID;
    logic [31:0] PC_sumado_ID;
    logic        valid_ID;
    logic        halted;
`ifdef IF_PERF_COUNTER_EN
    logic [31:0] fetch_count;
`endif

    bit          halt_en = 1'b0;
    logic [31:0] halt_addr = 32'h0;

    int checks = 0;
    int failures = 0;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .IF_Flush       (IF_Flush),
        .instruction_IF (instruction_IF),
        .PC_sumado_IF   (PC_sumado_IF),
        .instruction_ID (instruction_ID),
        .PC_sumado_ID   (PC_sumado_ID),
        .valid_ID       (valid_ID),
        .halted         (halted)
`ifdef IF_PERF_COUNTER_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: a hashed word per address, plus one
    // optional halt word.
    function automatic logic [31:0] mem_word(input logic [31:0] a,
                                             input bit hen,
                                             input logic [31:0] ha);
        logic [31:0] w;
        if (hen && a == ha) return HALT;
        w = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        if (w == HALT) w = w ^ 32'h1;
        return w;
    endfunction

    always_comb imem_data = mem_word(imem_addr, halt_en, halt_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] iid;
        logic [31:0] pid;
        logic [31:0] cnt;
        bit          vid;
        bit          hlt;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit          m_booted;
    bit          m_halted;
    int          m_hcyc;
    logic [31:0] m_pc;
    logic [31:0] m_iid;
    logic [31:0] m_pid;
    logic [31:0] m_cnt;
    bit          m_vid;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booted = 0;
        m_halted = 0;
        m_hcyc   = 0;
        m_pc     = 32'h0;
        m_iid    = 32'h0;
        m_pid    = 32'h0;
        m_vid    = 0;
        m_cnt    = 32'h0;
    endtask

    // One clock of the fetch stage as described by its rules.
    task automatic model_step(input bit st, input bit fl, input bit b,
                              input logic [31:0] bt, input bit j,
                              input logic [31:0] jt);
        logic [31:0] word;
        logic [31:0] next_pc;
        word = mem_word(m_pc, halt_en, halt_addr);
        if (!m_booted) begin
            m_booted = 1;
            m_iid = 0;
            m_pid = 0;
            m_vid = 0;
        end else if (m_halted) begin
            m_hcyc++;
        end else begin
            if (j) next_pc = jt & ~32'd3;
            else if (b) next_pc = bt & ~32'd3;
            else if (st) next_pc = m_pc;
            else next_pc = m_pc + 4;
            if (fl || j || b) begin
                m_iid = 0;
                m_vid = 0;
                m_pid = m_pc + 4;
            end else if (!st && word == HALT) begin
                m_halted = 1;
                m_iid = 0;
                m_vid = 0;
                next_pc = m_pc;
            end else if (!st) begin
                m_iid = word;
                m_pid = m_pc + 4;
                m_vid = 1;
                m_cnt = m_cnt + 1;
            end
            m_pc = next_pc;
        end
    endtask

    task automatic step(input bit st, input bit fl, input bit b,
                        input logic [31:0] bt, input bit j,
                        input logic [31:0] jt);
        exp_t e;
        @(negedge clk);
        stall = st;
        IF_Flush = fl;
        branch_taken = b;
        branch_target = bt;
        jump = j;
        jump_target = jt;
        model_step(st, fl, b, bt, j, jt);
        e.pc  = m_pc;
        e.iid = m_iid;
        e.pid = m_pid;
        e.vid = m_vid;
        e.hlt = m_halted;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted between clock edges so the clear must be async.
    task automatic do_reset(input bit hen, input logic [31:0] ha);
        @(negedge clk);
        #2;
        reset = 1'b1;
        stall = 0;
        IF_Flush = 0;
        branch_taken = 0;
        jump = 0;
        halt_en = hen;
        halt_addr = ha;
        model_reset();
        #1;
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr_id", instruction_ID, 32'h0);
        chk("rst_pcs_id", PC_sumado_ID, 32'h0);
        chk("rst_valid_id", {31'h0, valid_ID}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
`ifdef IF_PERF_COUNTER_EN
        chk("rst_fetch_count", fetch_count, 32'h0);
`endif
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: compares every registered edge against the model.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("imem_addr", imem_addr, e.pc);
                chk("instruction_IF", instruction_IF,
                    mem_word(e.pc, halt_en, halt_addr));
                chk("PC_sumado_IF", PC_sumado_IF, e.pc + 32'd4);
                chk("instruction_ID", instruction_ID, e.iid);
                chk("valid_ID", {31'h0, valid_ID}, {31'h0, e.vid});
                chk("halted", {31'h0, halted}, {31'h0, e.hlt});
                if (e.vid) chk("PC_sumado_ID", PC_sumado_ID, e.pid);
`ifdef IF_PERF_COUNTER_EN
                chk("fetch_count", fetch_count, e.cnt);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] t;
        int guard;
        model_reset();

        // Sequential fetch, stall at 0x10, branch+stall at 0x20
        do_reset(0, 0);
        idle(5);
        chk("pc_at_0x10", m_pc, 32'h10);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        guard = 0;
        while (m_pc != 32'h20 && guard < 20) begin
            idle(1);
            guard++;
        end
        step(1, 0, 1, 32'h40, 0, 0);
        idle(2);
        // Jump beats branch
        step(0, 0, 1, 32'h40, 1, 32'h100);
        idle(2);
        // Flush alone, flush under stall
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        idle(2);
        // Wrap from the top of the address space, misaligned target
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
        idle(12);

        // Halt word at 0x0C; redirects afterwards ignored
        do_reset(1, 32'h0C);
        idle(5);
        step(0, 0, 1, 32'h200, 0, 0);
        step(1, 1, 1, 32'h80, 1, 32'h300);
        idle(2);
        chk("halt_model_pc", m_pc, 32'h0C);

        // Halt word under stall is re-examined; under flush discarded
        do_reset(1, 32'h08);
        idle(3);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 32'h8, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(3);

        // Randomized phase
        do_reset($urandom_range(0, 1), {24'h0, 6'($urandom_range(0, 63)), 2'b00});
        for (int i = 0; i < 500; i++) begin
            if ((m_halted && m_hcyc > 4) || $urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(0, 1),
                         {24'h0, 6'($urandom_range(0, 63)), 2'b00});
            end else begin
                t = 32'($urandom_range(0, 255));
                step($urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 8,
                     $urandom_range(0, 99) < 10, t,
                     $urandom_range(0, 99) < 5,
                     32'($urandom_range(0, 255)));
            end
        end

        idle(1);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
